// File: rtl/rdc_fix_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rdc_fix_pipe
// Brief    : 2-stage fixed-point precision reducer (shift/round, then saturate)
//            with valid/ready flow control and a sticky overflow-beat counter.
//            Optional macro RDC_FIX_ROUND_EN: round half toward +inf, else floor.
// Revision : 1.0
// ============================================================================
module rdc_fix_pipe #(
  parameter int I_PREC = 16,
  parameter int O_PREC = 8,
  parameter int SHIFT  = 4,
  parameter int SIGN   = 1,
  parameter int CH     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*I_PREC-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH*O_PREC-1:0]   out_data,
  output logic [CH-1:0]          out_ovf,
  input  logic                   cnt_clr,
  output logic [15:0]            ovf_cnt
);

  localparam int c_R_W = I_PREC - SHIFT + 1;
  localparam int c_E_W = I_PREC + 1;

  logic                  r_s1_valid;
  logic                  r_s2_valid;
  logic [CH*c_R_W-1:0]   r_s1_data;
  logic [CH*c_R_W-1:0]   w_s1_next;
  logic [CH*O_PREC-1:0]  w_sat_data;
  logic [CH-1:0]         w_sat_ovf;
  logic [CH*O_PREC-1:0]  r_out_data;
  logic [CH-1:0]         r_out_ovf;
  logic [15:0]           r_ovf_cnt;
  logic                  w_s1_ld;
  logic                  w_s2_ld;

  assign w_s2_ld  = !r_s2_valid || out_ready;
  assign w_s1_ld  = !r_s1_valid || w_s2_ld;
  assign in_ready = w_s1_ld;

  generate
    for (genvar k = 0; k < CH; k++) begin : g_ch
      logic [c_E_W-1:0] w_ext;
      logic [c_E_W-1:0] w_sum;
      logic [c_R_W-1:0] w_r;
      logic             w_unused_lsb;

      assign w_ext = {((SIGN != 0) ? in_data[k*I_PREC + I_PREC - 1] : 1'b0),
                      in_data[k*I_PREC +: I_PREC]};
`ifdef RDC_FIX_ROUND_EN
      localparam logic [c_E_W-1:0] c_HALF = c_E_W'(1) << (SHIFT - 1);
      assign w_sum = w_ext + c_HALF;
`else
      assign w_sum = w_ext;
`endif
      // The extended top bit makes this slice equal to >>> (signed) or >> (unsigned).
      assign w_s1_next[k*c_R_W +: c_R_W] = w_sum[c_E_W-1:SHIFT];
      assign w_unused_lsb = ^w_sum[SHIFT-1:0];

      assign w_r = r_s1_data[k*c_R_W +: c_R_W];
      if (SIGN != 0) begin : g_sat_s
        logic w_ovf;
        assign w_ovf = !((&w_r[c_R_W-1:O_PREC-1]) || !(|w_r[c_R_W-1:O_PREC-1]));
        assign w_sat_ovf[k] = w_ovf;
        assign w_sat_data[k*O_PREC +: O_PREC] =
          !w_ovf         ? w_r[O_PREC-1:0] :
          w_r[c_R_W-1]   ? {1'b1, {(O_PREC-1){1'b0}}} :
                           {1'b0, {(O_PREC-1){1'b1}}};
      end else begin : g_sat_u
        logic w_ovf;
        assign w_ovf = |w_r[c_R_W-1:O_PREC];
        assign w_sat_ovf[k] = w_ovf;
        assign w_sat_data[k*O_PREC +: O_PREC] = w_ovf ? {O_PREC{1'b1}} : w_r[O_PREC-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_data  <= '0;
      r_out_data <= '0;
      r_out_ovf  <= '0;
    end else begin
      if (w_s1_ld) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data <= w_s1_next;
        end
      end
      if (w_s2_ld) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_sat_data;
          r_out_ovf  <= w_sat_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      r_ovf_cnt <= '0;
    end else if (r_s2_valid && out_ready && (|r_out_ovf) && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign ovf_cnt   = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rdc_fix_pipe.sv
`default_nettype none
// Scoreboard bench for rdc_fix_pipe: a signed and an unsigned instance share
// stimulus; expectations come from an integer-arithmetic model or constants.
module tb_rdc_fix_pipe;
  localparam int I_PREC = 16;
  localparam int O_PREC = 8;
  localparam int SHIFT  = 4;
  localparam int CH     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready_s, in_ready_u, out_valid_s, out_valid_u;
  logic [15:0] out_data_s, out_data_u, ovf_cnt_s, ovf_cnt_u;
  logic [1:0]  out_ovf_s, out_ovf_u;

  always #5 clk = ~clk;

  rdc_fix_pipe #(.I_PREC(I_PREC), .O_PREC(O_PREC), .SHIFT(SHIFT), .SIGN(1), .CH(CH)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_ovf(out_ovf_s),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt_s));

  rdc_fix_pipe #(.I_PREC(I_PREC), .O_PREC(O_PREC), .SHIFT(SHIFT), .SIGN(0), .CH(CH)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u), .out_ovf(out_ovf_u),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt_u));

  typedef struct {
    logic [15:0] ds;
    logic [1:0]  os;
    logic [15:0] du;
    logic [1:0]  ou;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // One channel: scale by 2^-SHIFT (floor, optionally +half first), then clamp.
  function automatic logic [8:0] ref_ch(input logic [15:0] x, input bit sgn);
    longint v, qv, lo, hi, dv;
    dv = longint'(1) << SHIFT;
    v  = sgn ? longint'($signed(x)) : longint'(x);
`ifdef RDC_FIX_ROUND_EN
    v = v + dv / 2;
`endif
    qv = (v >= 0) ? v / dv : -((-v + dv - 1) / dv);
    lo = sgn ? -(longint'(1) << (O_PREC - 1)) : 0;
    hi = sgn ? (longint'(1) << (O_PREC - 1)) - 1 : (longint'(1) << O_PREC) - 1;
    if (qv > hi) return {1'b1, 8'(hi)};
    if (qv < lo) return {1'b1, 8'(lo)};
    return {1'b0, 8'(qv)};
  endfunction

  function automatic exp_t model(input logic [31:0] d);
    logic [8:0] a, b, c, e2;
    exp_t e;
    a  = ref_ch(d[15:0], 1'b1);
    b  = ref_ch(d[31:16], 1'b1);
    c  = ref_ch(d[15:0], 1'b0);
    e2 = ref_ch(d[31:16], 1'b0);
    e.ds = {b[7:0], a[7:0]};
    e.os = {b[8], a[8]};
    e.du = {e2[7:0], c[7:0]};
    e.ou = {e2[8], c[8]};
    return e;
  endfunction

  task automatic send(input logic [31:0] d, input exp_t e);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_s) begin
      in_valid = 1'b0;
      check("in_ready_timeout", {31'd0, in_ready_s}, 32'd1);
      return;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] d);
    send(d, model(d));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", q.size(), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on each output handshake, checks stall stability and the counter.
  initial begin
    exp_t        e;
    logic [15:0] exp_cnt_s = '0, exp_cnt_u = '0;
    bit          cnt_known = 1'b0;
    bit          stall_prev = 1'b0;
    logic [15:0] prev_ds, prev_du;
    logic [1:0]  prev_os, prev_ou;
    forever begin
      @(negedge clk);
      if (cnt_known) begin
        check("ovf_cnt_s", ovf_cnt_s, exp_cnt_s);
        check("ovf_cnt_u", ovf_cnt_u, exp_cnt_u);
      end
      if (!reset && stall_prev) begin
        check("stall_valid", {31'd0, out_valid_s}, 32'd1);
        check("stall_data", {out_data_s, out_data_u}, {prev_ds, prev_du});
        check("stall_ovf", {out_ovf_s, out_ovf_u}, {prev_os, prev_ou});
      end
      if (!reset && out_valid_s && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", {16'd0, out_data_s}, 32'hDEAD);
        end else begin
          e = q.pop_front();
          check("valid_u", {31'd0, out_valid_u}, 32'd1);
          check("data_s", out_data_s, e.ds);
          check("ovf_s", out_ovf_s, e.os);
          check("data_u", out_data_u, e.du);
          check("ovf_u", out_ovf_u, e.ou);
        end
      end
      stall_prev = !reset && out_valid_s && !out_ready;
      prev_ds = out_data_s; prev_du = out_data_u;
      prev_os = out_ovf_s;  prev_ou = out_ovf_u;
      if (reset || cnt_clr) begin
        exp_cnt_s = '0;
        exp_cnt_u = '0;
      end else begin
        if (out_valid_s && out_ready && |out_ovf_s && exp_cnt_s != 16'hFFFF) exp_cnt_s++;
        if (out_valid_u && out_ready && |out_ovf_u && exp_cnt_u != 16'hFFFF) exp_cnt_u++;
      end
      cnt_known = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    exp_t sat_e;
    sat_e.ds = 16'h807F; sat_e.os = 2'b11; sat_e.du = 16'hFFFF; sat_e.ou = 2'b11;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
    check("rst_out_data", {out_data_s, out_data_u}, 32'd0);
    check("rst_out_ovf", {28'd0, out_ovf_s, out_ovf_u}, 32'd0);
    check("rst_ovf_cnt", ovf_cnt_s, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready_s}, 32'd1);
    @(posedge clk);
    #1;

`ifdef RDC_FIX_ROUND_EN
    e.ds = 16'h0013; e.os = 2'b00; e.du = 16'h0013; e.ou = 2'b00;
`else
    e.ds = 16'h0012; e.os = 2'b00; e.du = 16'h0012; e.ou = 2'b00;
`endif
    send(32'h0000_0128, e);
    send(32'h8000_7FFF, sat_e);
`ifdef RDC_FIX_ROUND_EN
    e.ds = 16'h007F; e.os = 2'b01; e.du = 16'h00FF; e.ou = 2'b01;
`else
    e.ds = 16'h007F; e.os = 2'b01; e.du = 16'h00FF; e.ou = 2'b00;
`endif
    send(32'h0000_0FF8, e);
`ifdef RDC_FIX_ROUND_EN
    e.ds = 16'h0000; e.os = 2'b00; e.du = 16'h00FF; e.ou = 2'b01;
`else
    e.ds = 16'h00FF; e.os = 2'b00; e.du = 16'h00FF; e.ou = 2'b01;
`endif
    send(32'h0000_FFF8, e);
    send(32'h8000_7FFF, sat_e);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_m($urandom);
    drain();
    for (int i = 0; i < 200; i++) begin
      send_m($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 65536; i++) send(32'h8000_7FFF, sat_e);
    drain();
    check("cnt_saturated", ovf_cnt_s, 32'h0000_FFFF);
    send(32'h8000_7FFF, sat_e);
    drain();
    check("cnt_stays_ffff", ovf_cnt_s, 32'h0000_FFFF);

    send(32'h8000_7FFF, sat_e);
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr_wins", ovf_cnt_s, 32'd0);
    drain();

    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_m($urandom);
    send_m($urandom);
    reset = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid_s}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready_s}, 32'd1);
    rdy_mode = 1;
    repeat (20) @(posedge clk);
    #1;
    send_m($urandom);
    send_m(32'h0000_0128);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rdc_fix_pipe.md
RDC_FIX_PIPE -- requirements
Module: rdc_fix_pipe

Interface
REQ-001 The block SHALL provide parameter I_PREC, default 16: input element width in bits.
REQ-002 The block SHALL provide parameter O_PREC, default 8: output element width in bits.
REQ-003 The block SHALL provide parameter SHIFT, default 4: number of fractional LSBs dropped; legal range 1..I_PREC-O_PREC.
REQ-004 The block SHALL provide parameter SIGN, default 1: 1 = two's-complement elements, 0 = unsigned elements.
REQ-005 The block SHALL provide parameter CH, default 2: number of parallel channels per beat.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, CH*I_PREC); channel k occupies bits [k*I_PREC +: I_PREC].
REQ-009 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, CH*O_PREC) and out_ovf (output, CH): one saturation flag per channel.
REQ-010 The block SHALL have ports cnt_clr (input, 1) and ovf_cnt (output, 16): a sticky count of overflowed beats.

Function
REQ-011 The block SHALL be a 2-stage pipeline: stage 1 shifts and rounds, stage 2 saturates and registers the output; latency from input acceptance to out_valid is 2 cycles.
REQ-012 Each stage SHALL load when it is empty or its contents are being consumed; in_ready = !s1_valid || !s2_valid || out_ready.
REQ-013 Full throughput SHALL be sustained: 1 beat per cycle while out_ready=1, with no bubbles.
REQ-014 While out_valid=1 and out_ready=0, out_data and out_ovf SHALL hold stable; no beat SHALL be dropped or duplicated.
REQ-015 Stage 1 SHALL compute r = in >>> SHIFT (arithmetic if SIGN=1, logical if SIGN=0) into I_PREC-SHIFT+1 bits, so a rounding carry is never lost.
REQ-016 Stage 2 SHALL saturate each channel independently.
- SIGN=1: range [-2^(O_PREC-1), 2^(O_PREC-1)-1].
- SIGN=0: range [0, 2^O_PREC-1].
- Out-of-range values clamp to the nearer bound, and out_ovf[k]=1 for that channel.
REQ-017 ovf_cnt SHALL increment by 1 on each cycle where out_valid && out_ready && |out_ovf.
- It saturates at 0xFFFF and does not wrap.
- cnt_clr=1 sets it to 0 on the next edge; clear wins over a simultaneous increment.

Reset
REQ-018 On reset, s1_valid, s2_valid, out_valid, out_ovf, out_data and ovf_cnt SHALL become 0, and in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-019 Reset asserted mid-stream SHALL discard all in-flight beats; no output beat derived from pre-reset input SHALL appear after reset.

Configuration
REQ-020 With macro RDC_FIX_ROUND_EN defined, stage 1 SHALL add 2^(SHIFT-1) before shifting (round half toward +infinity); the sum is computed without overflow.
REQ-021 With RDC_FIX_ROUND_EN undefined, stage 1 SHALL truncate (floor), with no adder; all other behaviour is identical.

Verification
REQ-022 The bench SHALL cover rounding: defaults, in_data channel 0 = 0x0128 -> out 0x13 with RDC_FIX_ROUND_EN, 0x12 without; ovf=0 in both cases.
REQ-023 The bench SHALL cover saturation: SIGN=1, channel 0 = 0x7FFF and channel 1 = 0x8000 -> out 0x7F/0x80, out_ovf=2'b11, ovf_cnt increments by 1 per accepted beat.
REQ-024 The bench SHALL cover the rounding carry in the unsigned case: SIGN=0, 0x0FF8 -> with rounding out 0xFF and ovf=1; without rounding out 0xFF and ovf=0. Also SIGN=1, 0xFFF8 -> 0x00 rounded, 0xFF truncated.
REQ-025 The bench SHALL cover backpressure: stream 8 beats with out_ready toggled pseudo-randomly -> all 8 outputs appear in order, exact, and stable while stalled.
REQ-026 The bench SHALL cover the counter and reset:
- Force ovf_cnt to 0xFFFF with overflowing beats, then send another -> stays 0xFFFF.
- Assert cnt_clr together with an overflow beat -> 0.
- Assert reset with 2 beats in flight -> out_valid=0 and no stale beats afterwards.
